// File: rtl/inreg.sv
// inreg: LZW input bit buffer. Collects MSB-first bytes into a 32-bit
// MSB-aligned shift register and hands out 13-bit codes until the end code
// 13'h1FFF is consumed.
// Optional feature: define INREG_STATS_EN to count consumed codes on code_cnt.
module inreg (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        load_byte,
  input  logic [7:0]  io_byte,
  input  logic        read_code,
  input  logic        flush,
  output logic        need_byte,
  output logic        code_valid,
  output logic [12:0] code_data,
  output logic        eoc,
  output logic        tc_inreg,
  output logic        err,
  output logic [15:0] code_cnt
);

  localparam int unsigned SREG_W = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned CODE_W = 13;
  localparam int unsigned BYTE_W = 8;

  localparam logic [CNT_W-1:0]  CNT_CODE  = CNT_W'(CODE_W);
  localparam logic [CNT_W-1:0]  CNT_BYTE  = CNT_W'(BYTE_W);
  localparam logic [CNT_W-1:0]  CNT_LDMAX = CNT_W'(SREG_W - BYTE_W);
  localparam logic [CODE_W-1:0] END_CODE  = 13'h1FFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [SREG_W-1:0]   r_sreg;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err;

  logic                w_run;
  logic                w_rd_ok;
  logic                w_rd_err;
  logic [CNT_W-1:0]    w_cnt_base;
  logic [SREG_W-1:0]   w_sreg_base;
  logic                w_ld_ok;
  logic                w_ld_err;
  logic [CNT_W-1:0]    w_ld_sh;
  logic [SREG_W-1:0]   w_ld_bits;
  logic [SREG_W-1:0]   w_sreg_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CODE_W-1:0]   w_code;

  // Read is resolved first; a load is then judged against the post-read count
  assign w_run       = (r_state == ST_RUN);
  assign w_code      = r_sreg[SREG_W-1 -: CODE_W];
  assign w_rd_ok     = w_run && read_code && (r_cnt >= CNT_CODE);
  assign w_rd_err    = w_run && read_code && (r_cnt <  CNT_CODE);
  assign w_cnt_base  = w_rd_ok ? CNT_W'(r_cnt - CNT_CODE) : r_cnt;
  assign w_sreg_base = w_rd_ok ? (r_sreg << CODE_W) : r_sreg;
  assign w_ld_ok     = w_run && load_byte && (w_cnt_base <= CNT_LDMAX);
  assign w_ld_err    = w_run && load_byte && (w_cnt_base >  CNT_LDMAX);
  assign w_ld_sh     = CNT_W'(CNT_LDMAX - w_cnt_base);
  assign w_ld_bits   = SREG_W'(io_byte) << w_ld_sh;
  assign w_sreg_nxt  = w_ld_ok ? (w_sreg_base | w_ld_bits) : w_sreg_base;
  assign w_cnt_nxt   = w_ld_ok ? CNT_W'(w_cnt_base + CNT_BYTE) : w_cnt_base;

  // Control state machine and bit buffer; priority rst > start > flush > load/read
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else if (start) begin
      r_state <= ST_RUN;
      r_sreg  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else if (flush) begin
      r_sreg  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_sreg <= w_sreg_nxt;
          r_cnt  <= w_cnt_nxt;
          if (w_rd_err || w_ld_err) begin
            r_err <= 1'b1;
          end
          if (w_rd_ok && (w_code == END_CODE)) begin
            r_state <= ST_DONE;
          end
        end
        ST_IDLE, ST_DONE: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef INREG_STATS_EN
  logic [15:0] r_code_cnt;

  // Count every accepted code, including the end code; wraps naturally
  always_ff @(posedge clk) begin
    if (rst || start) begin
      r_code_cnt <= '0;
    end else if (!flush && w_rd_ok) begin
      r_code_cnt <= 16'(r_code_cnt + 16'd1);
    end
  end

  assign code_cnt = r_code_cnt;
`else
  assign code_cnt = 16'h0000;
`endif

  // Status outputs decoded from registered state
  assign need_byte  = w_run && (r_cnt <= CNT_LDMAX);
  assign code_valid = w_run && (r_cnt >= CNT_CODE);
  assign code_data  = w_code;
  assign eoc        = (r_state == ST_DONE);
  assign tc_inreg   = (r_cnt == '0);
  assign err        = r_err;

endmodule

// File: tb/tb_inreg.sv
// Scoreboard bench for inreg: a bit-queue reference model predicts the
// outputs after each driven cycle; a monitor compares them after each edge.
module tb_inreg;

  logic        clk;
  logic        rst;
  logic        start;
  logic        load_byte;
  logic [7:0]  io_byte;
  logic        read_code;
  logic        flush;
  logic        need_byte;
  logic        code_valid;
  logic [12:0] code_data;
  logic        eoc;
  logic        tc_inreg;
  logic        err;
  logic [15:0] code_cnt;

  inreg dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_byte  (load_byte),
    .io_byte    (io_byte),
    .read_code  (read_code),
    .flush      (flush),
    .need_byte  (need_byte),
    .code_valid (code_valid),
    .code_data  (code_data),
    .eoc        (eoc),
    .tc_inreg   (tc_inreg),
    .err        (err),
    .code_cnt   (code_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        need;
    logic        valid;
    logic [12:0] data;
    logic        eoc;
    logic        tc;
    logic        err;
    logic [15:0] cc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: buffer is literally a queue of bits, oldest first
  bit          m_bits[$];
  bit          m_running = 0;
  bit          m_done = 0;
  bit          m_err = 0;
  logic [15:0] m_cc = 16'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, expv);
    end
  endtask

  function automatic exp_t snapshot();
    exp_t e;
    logic [12:0] d;
    d = '0;
    for (int i = 0; i < 13; i++) begin
      d = {d[11:0], (i < m_bits.size()) ? m_bits[i] : 1'b0};
    end
    e.need  = m_running && (m_bits.size() <= 24);
    e.valid = m_running && (m_bits.size() >= 13);
    e.data  = d;
    e.eoc   = m_done;
    e.tc    = (m_bits.size() == 0);
    e.err   = m_err;
    e.cc    = m_cc;
    return e;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit ld, input logic [7:0] b,
                            input bit rd, input bit fl);
    bit          was_run;
    logic [12:0] code;
    if (r) begin
      m_bits.delete(); m_running = 0; m_done = 0; m_err = 0; m_cc = 0;
    end else if (s) begin
      m_bits.delete(); m_running = 1; m_done = 0; m_err = 0; m_cc = 0;
    end else if (fl) begin
      m_bits.delete();
    end else if (m_running) begin
      was_run = 1;
      if (rd) begin
        if (m_bits.size() >= 13) begin
          code = '0;
          for (int i = 0; i < 13; i++) code = {code[11:0], m_bits.pop_front()};
`ifdef INREG_STATS_EN
          m_cc = m_cc + 16'd1;
`endif
          if (code == 13'h1FFF) begin
            m_running = 0;
            m_done = 1;
          end
        end else begin
          m_err = 1;
        end
      end
      if (ld && was_run) begin
        if (m_bits.size() <= 24) begin
          for (int i = 7; i >= 0; i--) m_bits.push_back(b[i]);
        end else begin
          m_err = 1;
        end
      end
    end
  endtask

  // Drive one cycle of inputs and queue the predicted post-edge outputs
  task automatic cyc(input bit r, input bit s, input bit ld, input logic [7:0] b,
                     input bit rd, input bit fl);
    @(negedge clk);
    rst = r; start = s; load_byte = ld; io_byte = b; read_code = rd; flush = fl;
    model_step(r, s, ld, b, rd, fl);
    exp_q.push_back(snapshot());
  endtask

  task automatic idle();
    cyc(0, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic ld(input logic [7:0] b);
    cyc(0, 0, 1, b, 0, 0);
  endtask

  // Monitor: compare DUT outputs against the oldest pending prediction
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("need_byte",  32'(need_byte),  32'(e.need));
      chk("code_valid", 32'(code_valid), 32'(e.valid));
      chk("code_data",  32'(code_data),  32'(e.data));
      chk("eoc",        32'(eoc),        32'(e.eoc));
      chk("tc_inreg",   32'(tc_inreg),   32'(e.tc));
      chk("err",        32'(err),        32'(e.err));
      chk("code_cnt",   32'(code_cnt),   32'(e.cc));
    end
  end

  initial begin
    bit r, s, l, rd, fl;
    logic [7:0] b;
    rst = 1; start = 0; load_byte = 0; io_byte = 0; read_code = 0; flush = 0;

    // Reset state, basic decode
    cyc(1, 0, 0, 8'h00, 0, 0);
    cyc(0, 1, 0, 8'h00, 0, 0);
    ld(8'h00); ld(8'h08);
    cyc(0, 0, 0, 8'h00, 1, 0);
    idle();

    // End code, then ignored load
    cyc(0, 1, 0, 8'h00, 0, 0);
    ld(8'hFF); ld(8'hF8);
    cyc(0, 0, 0, 8'h00, 1, 0);
    ld(8'h55);
    cyc(0, 0, 0, 8'h00, 1, 0);
    idle();

    // Simultaneous strobes at cnt 16, then drain to expose the new byte
    cyc(0, 1, 0, 8'h00, 0, 0);
    ld(8'h00); ld(8'h08);
    cyc(0, 0, 1, 8'hAB, 1, 0);
    ld(8'h00);
    cyc(0, 0, 0, 8'h00, 1, 0);

    // Illegal load, then start clears
    cyc(0, 1, 0, 8'h00, 0, 0);
    ld(8'h11); ld(8'h22); ld(8'h33); ld(8'h44); ld(8'h55);
    cyc(0, 0, 1, 8'h66, 1, 0);
    cyc(0, 1, 0, 8'h00, 0, 0);

    // Illegal read and flush
    ld(8'h9C);
    cyc(0, 0, 0, 8'h00, 1, 0);
    cyc(0, 0, 1, 8'h77, 1, 1);
    idle();

    // Reset mid-operation with codes counted
    cyc(0, 1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) begin
      ld(8'h00); ld(8'h00);
      cyc(0, 0, 0, 8'h00, 1, 0);
    end
    cyc(1, 0, 1, 8'hA5, 0, 0);
    idle();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 59) == 0);
      fl = ($urandom_range(0, 39) == 0);
      l  = ($urandom_range(0, 99) < 55);
      rd = ($urandom_range(0, 99) < 40);
      b  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      cyc(r, s, l, b, rd, fl);
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
